// File: rtl/icache_line_ctrl_if.sv
// mmm_pkg: fetch address geometry shared by the line controller and its users.
//   XLEN          - address / instruction word width
//   ICACHE_OFFSET - log2(words per line)
//   OFFSET        - log2(bytes per word)
//
// icache_line_ctrl_if: refill port between the line controller (master) and
// the instruction memory (slave).
//   mem_req_valid_o - refill request valid (master -> slave)
//   mem_req_addr_o  - line-aligned refill address (master -> slave)
//   mem_req_ready_i - memory accepts the request (slave -> master)
//   mem_rsp_valid_i - refill line valid, one beat per request (slave -> master)
//   mem_rsp_data_i  - full refill line (slave -> master)
package mmm_pkg;
  parameter int XLEN          = 32;
  parameter int ICACHE_OFFSET = 2;
  parameter int OFFSET        = 2;
endpackage

interface icache_line_ctrl_if #(
  parameter int XLEN   = mmm_pkg::XLEN,
  parameter int LINE_W = mmm_pkg::XLEN << mmm_pkg::ICACHE_OFFSET
);
  logic              mem_req_valid_o;
  logic [XLEN-1:0]   mem_req_addr_o;
  logic              mem_req_ready_i;
  logic              mem_rsp_valid_i;
  logic [LINE_W-1:0] mem_rsp_data_i;

  modport master (
    output mem_req_valid_o, mem_req_addr_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
  );

  modport slave (
    input  mem_req_valid_o, mem_req_addr_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
  );
endinterface

// File: rtl/icache_line_ctrl.sv
// presence_checker: tag comparison of the fetch address against the held line
// (here_o) and against the address of the outstanding refill (will_be_here_o).
//
// icache_line_ctrl: single-line instruction fetch buffer.
//   clk_i, rst_i      - clock, synchronous active-high reset
//   fetch_req_i, pc_i - fetch request and address
//   flush_i           - invalidate line, discard any in-flight refill
//   instr_valid_o     - instr_o is valid for pc_i this cycle (0-cycle hit)
//   instr_o           - selected word of the held line (always driven)
//   mem               - refill request/response port (master side)
//   line_valid_o      - held line valid
//   line_pc_o         - aligned address of the held line
//   busy_o            - a refill is outstanding
module presence_checker
  import mmm_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] line_pc_i,
  input  logic            line_valid_i,
  input  logic [XLEN-1:0] prev_pc_i,
  output logic            here_o,
  output logic            will_be_here_o
);
  localparam int LO = ICACHE_OFFSET + OFFSET;

  assign here_o         = line_valid_i && ((pc_i >> LO) == (line_pc_i >> LO));
  assign will_be_here_o = (pc_i >> LO) == (prev_pc_i >> LO);
endmodule

module icache_line_ctrl
  import mmm_pkg::*;
#(
  parameter int LINE_W = XLEN << ICACHE_OFFSET
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      fetch_req_i,
  input  logic [XLEN-1:0]           pc_i,
  input  logic                      flush_i,
  output logic                      instr_valid_o,
  output logic [XLEN-1:0]           instr_o,
  icache_line_ctrl_if.master        mem,
  output logic                      line_valid_o,
  output logic [XLEN-1:0]           line_pc_o,
  output logic                      busy_o
);
  localparam int LO     = ICACHE_OFFSET + OFFSET;
  localparam int NWORDS = LINE_W / XLEN;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   line_pc_q, line_pc_d;
  logic              line_valid_q, line_valid_d;
  logic [LINE_W-1:0] line_data_q, line_data_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic              discard_q, discard_d;

  logic            here;
  logic            will_be_here;
  logic            in_flight;
  logic [XLEN-1:0] pc_aligned;
  logic [XLEN-1:0] words [NWORDS];

  presence_checker u_presence (
    .pc_i           (pc_i),
    .line_pc_i      (line_pc_q),
    .line_valid_i   (line_valid_q),
    .prev_pc_i      (pend_pc_q),
    .here_o         (here),
    .will_be_here_o (will_be_here)
  );

  // Only a refill that will actually land counts as in flight.
  assign in_flight  = will_be_here && busy_o && !discard_q;
  assign pc_aligned = (pc_i >> LO) << LO;

  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
    assign words[gi] = line_data_q[gi*XLEN +: XLEN];
  end

  assign instr_o       = words[pc_i[LO-1:OFFSET]];
  assign instr_valid_o = fetch_req_i && here && !flush_i;
  assign line_valid_o  = line_valid_q;
  assign line_pc_o     = line_pc_q;
  assign busy_o        = (state_q != S_IDLE);

  assign mem.mem_req_valid_o = (state_q == S_REQ);
  assign mem.mem_req_addr_o  = (state_q == S_REQ) ? pend_pc_q : '0;

  always_comb begin
    state_d      = state_q;
    line_pc_d    = line_pc_q;
    line_valid_d = line_valid_q;
    line_data_d  = line_data_q;
    pend_pc_d    = pend_pc_q;
    discard_d    = discard_q;

    case (state_q)
      S_IDLE: begin
        // Busy is low here, so in_flight is 0; kept for clarity of the rule.
        if (fetch_req_i && !here && !in_flight && !flush_i) begin
          pend_pc_d = pc_aligned;
          discard_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // A flush cannot retract a presented request; mark it stale instead.
        if (flush_i) discard_d = 1'b1;
        if (mem.mem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush_i) discard_d = 1'b1;
        if (mem.mem_rsp_valid_i) begin
          if (!(discard_q || flush_i)) begin
            line_data_d  = mem.mem_rsp_data_i;
            line_pc_d    = pend_pc_q;
            line_valid_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) line_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      line_pc_q    <= '0;
      line_valid_q <= 1'b0;
      line_data_q  <= '0;
      pend_pc_q    <= '0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_pc_q    <= line_pc_d;
      line_valid_q <= line_valid_d;
      line_data_q  <= line_data_d;
      pend_pc_q    <= pend_pc_d;
      discard_q    <= discard_d;
    end
  end
endmodule

// File: tb/tb_icache_line_ctrl.sv
module tb_icache_line_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_req_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic        line_valid_o;
  logic [31:0] line_pc_o;
  logic        busy_o;

  icache_line_ctrl_if mem_if ();

  icache_line_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .fetch_req_i   (fetch_req_i),
    .pc_i          (pc_i),
    .flush_i       (flush_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .mem           (mem_if),
    .line_valid_o  (line_valid_o),
    .line_pc_o     (line_pc_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [31:0] pc, input logic fl,
                       input logic rdy, input logic rsp, input logic [127:0] data);
    fetch_req_i            = f;
    pc_i                   = pc;
    flush_i                = fl;
    mem_if.mem_req_ready_i = rdy;
    mem_if.mem_rsp_valid_i = rsp;
    mem_if.mem_rsp_data_i  = data;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic         fetch;
    logic [31:0]  pc;
    logic         flush;
    logic         ready;
    logic         rsp;
    logic [127:0] data;
    logic         e_iv;
    logic [31:0]  e_instr;
    logic         e_rv;
    logic [31:0]  e_addr;
    logic         e_busy;
    logic         e_lv;
    logic [31:0]  e_lpc;
  } vec_t;

  function automatic vec_t mk(input logic f, input logic [31:0] pc, input logic fl,
                              input logic rdy, input logic rsp, input logic [127:0] d,
                              input logic iv, input logic [31:0] ins, input logic rv,
                              input logic [31:0] addr, input logic bsy, input logic lv,
                              input logic [31:0] lpc);
    vec_t v;
    v.fetch = f; v.pc = pc; v.flush = fl; v.ready = rdy; v.rsp = rsp; v.data = d;
    v.e_iv = iv; v.e_instr = ins; v.e_rv = rv; v.e_addr = addr;
    v.e_busy = bsy; v.e_lv = lv; v.e_lpc = lpc;
    return v;
  endfunction

  // Reference model: one held line plus at most one outstanding refill.
  logic        m_lv;
  logic [31:0] m_lpc;
  logic [31:0] m_data [4];
  logic        m_pend;
  logic        m_acc;
  logic        m_stale;
  logic [31:0] m_paddr;

  task automatic model_reset();
    m_lv = 0; m_lpc = 0; m_pend = 0; m_acc = 0; m_stale = 0; m_paddr = 0;
    for (int i = 0; i < 4; i++) m_data[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [16];
    logic [127:0] d1, d2, d3, d4, d5, rd;
    d1 = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    d2 = {32'h2003, 32'h2002, 32'h2001, 32'h2000};
    d3 = {32'h3003, 32'h3002, 32'h3001, 32'h3000};
    d4 = {32'h4003, 32'h4002, 32'h4001, 32'h4000};
    d5 = {32'h5003, 32'h5002, 32'h5001, 32'h5000};

    //           f  pc      fl rdy rsp data  iv ins       rv addr     bsy lv lpc
    tbl[0]  = mk(1, 32'h104, 0, 1, 0, 0,  0, 32'h0,    0, 32'h0,   0, 0, 32'h0);
    tbl[1]  = mk(1, 32'h104, 0, 1, 0, 0,  0, 32'h0,    1, 32'h100, 1, 0, 32'h0);
    tbl[2]  = mk(1, 32'h104, 0, 0, 1, d1, 0, 32'h0,    0, 32'h0,   1, 0, 32'h0);
    tbl[3]  = mk(1, 32'h104, 0, 0, 0, 0,  1, 32'hB1,   0, 32'h0,   0, 1, 32'h100);
    tbl[4]  = mk(1, 32'h100, 0, 0, 0, 0,  1, 32'hA0,   0, 32'h0,   0, 1, 32'h100);
    tbl[5]  = mk(1, 32'h108, 0, 0, 0, 0,  1, 32'hC2,   0, 32'h0,   0, 1, 32'h100);
    tbl[6]  = mk(1, 32'h10C, 0, 0, 0, 0,  1, 32'hD3,   0, 32'h0,   0, 1, 32'h100);
    tbl[7]  = mk(1, 32'h200, 0, 0, 0, 0,  0, 32'hA0,   0, 32'h0,   0, 1, 32'h100);
    tbl[8]  = mk(1, 32'h200, 0, 0, 0, 0,  0, 32'hA0,   1, 32'h200, 1, 1, 32'h100);
    tbl[9]  = tbl[8];
    tbl[10] = tbl[8];
    tbl[11] = tbl[8];
    tbl[12] = mk(1, 32'h200, 0, 1, 0, 0,  0, 32'hA0,   1, 32'h200, 1, 1, 32'h100);
    tbl[13] = mk(1, 32'h200, 0, 0, 0, 0,  0, 32'hA0,   0, 32'h0,   1, 1, 32'h100);
    tbl[14] = mk(1, 32'h200, 0, 0, 1, d2, 0, 32'hA0,   0, 32'h0,   1, 1, 32'h100);
    tbl[15] = mk(1, 32'h208, 0, 0, 0, 0,  1, 32'h2002, 0, 32'h0,   0, 1, 32'h200);

    // Reset: outputs low during and after reset.
    rst_i = 1;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    settle();
    chk("rst_iv", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_rv", mem_if.mem_req_valid_o, 0);
    chk("rst_addr", mem_if.mem_req_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_lv", line_valid_o, 0);
    chk("rst_lpc", line_pc_o, 0);
    rst_i = 0;
    tick();
    settle();
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_lv", line_valid_o, 0);
    chk("post_rst_rv", mem_if.mem_req_valid_o, 0);
    tick();

    // Cold miss, same-line hits, ready backpressure.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].fetch, tbl[i].pc, tbl[i].flush, tbl[i].ready, tbl[i].rsp, tbl[i].data);
      settle();
      $display("vec %0d pc=%0h iv=%0b instr=%0h rv=%0b busy=%0b", i, pc_i,
               instr_valid_o, instr_o, mem_if.mem_req_valid_o, busy_o);
      chk($sformatf("tbl%0d_iv", i), instr_valid_o, tbl[i].e_iv);
      chk($sformatf("tbl%0d_instr", i), instr_o, tbl[i].e_instr);
      chk($sformatf("tbl%0d_rv", i), mem_if.mem_req_valid_o, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_addr", i), mem_if.mem_req_addr_o, tbl[i].e_addr);
      chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
      chk($sformatf("tbl%0d_lv", i), line_valid_o, tbl[i].e_lv);
      chk($sformatf("tbl%0d_lpc", i), line_pc_o, tbl[i].e_lpc);
      tick();
    end

    // Flush during WAIT, one cycle before the response for 0x300.
    drive(1, 32'h300, 0, 0, 0, 0); settle(); chk("fw_idle_busy", busy_o, 0); tick();
    drive(1, 32'h300, 0, 1, 0, 0); settle(); chk("fw_req_addr", mem_if.mem_req_addr_o, 32'h300); tick();
    drive(1, 32'h300, 1, 0, 0, 0); settle(); chk("fw_flush_iv", instr_valid_o, 0); tick();
    drive(1, 32'h300, 0, 0, 1, d3); settle();
    chk("fw_rsp_lv", line_valid_o, 0);
    chk("fw_rsp_busy", busy_o, 1);
    chk("fw_rsp_iv", instr_valid_o, 0);
    tick();
    drive(1, 32'h300, 0, 0, 0, 0); settle();
    chk("fw_drop_busy", busy_o, 0);
    chk("fw_drop_lv", line_valid_o, 0);
    chk("fw_drop_lpc", line_pc_o, 32'h200);
    chk("fw_drop_iv", instr_valid_o, 0);
    tick();
    drive(1, 32'h300, 0, 1, 0, 0); settle();
    chk("fw_reissue_rv", mem_if.mem_req_valid_o, 1);
    chk("fw_reissue_addr", mem_if.mem_req_addr_o, 32'h300);
    tick();
    drive(1, 32'h300, 0, 0, 1, d3); settle(); tick();
    drive(1, 32'h304, 0, 0, 0, 0); settle();
    chk("fw_fill_iv", instr_valid_o, 1);
    chk("fw_fill_instr", instr_o, 32'h3001);
    chk("fw_fill_lpc", line_pc_o, 32'h300);
    tick();

    // Flush coincident with a response and with a hit.
    drive(1, 32'h400, 0, 0, 0, 0); settle(); tick();
    drive(1, 32'h400, 0, 1, 0, 0); settle(); tick();
    drive(1, 32'h304, 1, 0, 1, d4); settle();
    chk("fc_hit_iv", instr_valid_o, 0);
    chk("fc_instr", instr_o, 32'h3001);
    tick();
    drive(0, 32'h400, 0, 0, 0, 0); settle();
    chk("fc_lv", line_valid_o, 0);
    chk("fc_busy", busy_o, 0);
    chk("fc_lpc", line_pc_o, 32'h300);
    tick();

    // Reset mid-WAIT, then a stray response.
    drive(1, 32'h500, 0, 0, 0, 0); settle(); tick();
    drive(1, 32'h500, 0, 1, 0, 0); settle(); tick();
    drive(0, 32'h500, 0, 0, 0, 0); settle(); chk("rw_wait_busy", busy_o, 1);
    rst_i = 1; tick(); rst_i = 0;
    drive(0, 32'h500, 0, 0, 1, d5); settle();
    chk("rw_busy", busy_o, 0);
    chk("rw_rv", mem_if.mem_req_valid_o, 0);
    chk("rw_lv", line_valid_o, 0);
    chk("rw_lpc", line_pc_o, 0);
    tick();
    drive(1, 32'h500, 0, 0, 0, 0); settle();
    chk("rw_stray_lv", line_valid_o, 0);
    chk("rw_stray_iv", instr_valid_o, 0);
    chk("rw_stray_busy", busy_o, 0);
    tick();

    // Randomized run against the reference model.
    drive(0, 0, 0, 0, 0, 0);
    rst_i = 1; tick(); rst_i = 0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        f, fl, rdy, rsp, hit, r;
      logic [31:0] pc;
      r   = ($urandom_range(0, 199) == 0);
      f   = ($urandom_range(0, 3) != 0);
      pc  = 32'h1000 + (32'($urandom_range(0, 5)) << 4) + (32'($urandom_range(0, 3)) << 2)
            + 32'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 29) == 0);
      rdy = $urandom_range(0, 1) == 1;
      rsp = m_pend && m_acc && ($urandom_range(0, 2) == 0);
      rd  = {$urandom, $urandom, $urandom, $urandom};
      rst_i = r;
      drive(f, pc, fl, rdy, rsp, rd);
      settle();
      hit = m_lv && ((pc >> 4) == (m_lpc >> 4));
      chk("rnd_iv", instr_valid_o, f && hit && !fl);
      chk("rnd_instr", instr_o, m_data[pc[3:2]]);
      chk("rnd_rv", mem_if.mem_req_valid_o, m_pend && !m_acc);
      if (m_pend && !m_acc) chk("rnd_addr", mem_if.mem_req_addr_o, m_paddr);
      chk("rnd_busy", busy_o, m_pend);
      chk("rnd_lv", line_valid_o, m_lv);
      chk("rnd_lpc", line_pc_o, m_lpc);
      if (r) begin
        model_reset();
      end else begin
        if (m_pend && !m_acc) begin
          if (fl) m_stale = 1;
          if (rdy) m_acc = 1;
        end else if (m_pend) begin
          if (fl) m_stale = 1;
          if (rsp) begin
            if (!m_stale) begin
              m_lv  = 1;
              m_lpc = m_paddr;
              for (int w = 0; w < 4; w++) m_data[w] = rd[w*32 +: 32];
            end
            m_pend = 0;
          end
        end else if (f && !hit && !fl) begin
          m_pend  = 1;
          m_acc   = 0;
          m_stale = 0;
          m_paddr = {pc[31:4], 4'h0};
        end
        if (fl) m_lv = 0;
      end
      tick();
    end
    rst_i = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
